vasim_symbol_feeder: RTL and testbench
======================================

VASIM_SYMBOL_FEEDER -- requirements
Module: vasim_symbol_feeder

Interface
REQ-001 The block SHALL have one parameter: FLUSH_CYCLES, default 2, idle cycles between the final symbol and the done pulse (legal range 1..15).
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_data  input  32  packed symbol word; byte 0 = s_data[7:0] is sent first.
- s_valid  input  1  word offered.
- s_ready  output  1  word accepted on a cycle with s_valid && s_ready.
- s_last  input  1  word is the last word of the stream.
- s_nbytes  input  3  valid bytes in the last word (1..4); sampled only with s_last; 0 or >4 means 4.
- halt  input  1  downstream stall.
- symbols  output  8  symbol to the automata.
- run  output  1  symbols is valid this cycle.
- ste_reset  output  1  reset to the automata.
- sym_offset  output  32  index of the symbol currently on symbols.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle end-of-stream pulse.

Function
REQ-003 The FSM SHALL have states IDLE, INIT, FEED, FLUSH and DONE.
REQ-004 In IDLE: s_ready=0, ste_reset=1, run=0; s_valid=1 SHALL move the FSM to INIT on the next edge.
REQ-005 INIT SHALL last exactly one cycle with ste_reset=1, run=0, s_ready=0, and sym_offset cleared to 0, then go to FEED.
REQ-006 In FEED and FLUSH, ste_reset SHALL be 0.
REQ-007 FEED SHALL use a one-word holding register with a byte index.
- s_ready=1 when the register is empty, or when its final valid byte is emitted this cycle with halt=0.
REQ-008 A word accepted at edge N SHALL present its byte 0 on symbols with run=1 in cycle N+1.
REQ-009 Each cycle with halt=0 and a non-empty holding register SHALL drive run=1 and then advance the byte index.
REQ-010 Back-to-back words SHALL produce contiguous symbols with no bubble.
REQ-011 While halt=1: run=0, symbols held, byte index and sym_offset frozen, s_ready=0.
REQ-012 An empty holding register with no accepted word SHALL produce run=0 (a bubble) and leave sym_offset unchanged.
REQ-013 A last word SHALL emit only s_nbytes bytes; remaining bytes are discarded.
REQ-014 After the final byte is emitted, the FSM SHALL enter FLUSH for FLUSH_CYCLES cycles with run=0 and s_ready=0, then DONE.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-016 sym_offset SHALL increment by 1 after each cycle with run=1 and wrap modulo 2^32.
REQ-017 symbols SHALL hold its last value whenever run=0.

Reset
REQ-018 Asserting reset at any time SHALL take effect immediately:
- state=IDLE, holding register emptied and its data discarded;
- symbols=0, run=0, s_ready=0, ste_reset=1, sym_offset=0, busy=0, done=0.
REQ-019 After reset deasserts, the first stream SHALL start from IDLE per REQ-004.

Configuration
REQ-020 The macro VASIM_FEEDER_OFFSET_EN controls the offset counter.
- Defined: the 32-bit counter is built and sym_offset behaves per REQ-016.
- Undefined: no counter register is built and sym_offset is tied to 0; all other behaviour is unchanged.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single word 0x2D2D7C2B, s_last=1, s_nbytes=4, from IDLE: ste_reset=1 in INIT; then symbols 0x2B,0x7C,0x2D,0x2D with run=1 on 4 consecutive cycles; done pulses exactly FLUSH_CYCLES+1 cycles after the last symbol.
- Two words 0x04030201 then 0x08070605 (last, nbytes=4) offered back-to-back: symbols 0x01..0x08 on 8 contiguous run cycles; s_ready=1 on the 4th symbol of word 1.
- Last word 0xAABB2D7C with s_nbytes=2: only 0x7C and 0x2D emitted, then FLUSH.
- halt=1 for 3 cycles while the 2nd byte of a word is current: run=0 for 3 cycles, symbols held, then the remaining bytes resume in order; with macro on, sym_offset stays 1 during the halt.
- reset pulse during FEED after 2 of 4 bytes: all outputs go to reset values immediately; a new stream restarts at IDLE and the discarded bytes never appear.
- Macro on, 6-symbol stream: sym_offset reads 0..5 on the run cycles. Macro off, same stream: sym_offset=0 throughout.

Source files
------------

// File: rtl/vasim_symbol_feeder.sv
// Unpacks 32-bit stream words into byte symbols for an automata engine, with STE reset, halt and flush/done sequencing.
// Build option: define VASIM_FEEDER_OFFSET_EN to build the sym_offset counter; otherwise sym_offset is tied to 0.
module vasim_symbol_feeder #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [2:0]  s_nbytes,
    input  logic        halt,
    output logic [7:0]  symbols,
    output logic        run,
    output logic        ste_reset,
    output logic [31:0] sym_offset,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for s_valid, automata held in reset
    // INIT  | one cycle of STE reset, offset cleared
    // FEED  | emitting bytes from the holding register
    // FLUSH | FLUSH_CYCLES idle cycles after the final symbol
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, INIT, FEED, FLUSH, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_data;
    logic        hold_full;
    logic [1:0]  byte_idx;
    logic [2:0]  hold_cnt;
    logic        last_taken;
    logic [3:0]  flush_cnt;
    logic [7:0]  sym_q;
    logic        emit;
    logic        final_emit;
    logic        accept;
    logic [31:0] hold_shift;
    logic [7:0]  cur_byte;
    logic [2:0]  nbytes_dec;

    assign nbytes_dec = (s_nbytes == 3'd0 || s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
    assign hold_shift = hold_data >> {byte_idx, 3'b000};
    assign cur_byte   = hold_shift[7:0];
    assign accept     = s_valid && s_ready;
    assign busy       = (state != IDLE);
    assign symbols    = run ? cur_byte : sym_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        emit       = 1'b0;
        final_emit = 1'b0;
        s_ready    = 1'b0;
        run        = 1'b0;
        ste_reset  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ste_reset = 1'b1;
                if (s_valid) state_nxt = INIT;
            end
            INIT: begin
                ste_reset = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                emit       = hold_full && !halt;
                final_emit = emit && ({1'b0, byte_idx} == hold_cnt - 3'd1);
                run        = emit;
                // Once the last word is in, nothing more is taken until the next stream.
                s_ready    = !halt && !last_taken && (!hold_full || final_emit);
                if (final_emit && last_taken) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            byte_idx   <= '0;
            hold_cnt   <= 3'd4;
            last_taken <= 1'b0;
            sym_q      <= '0;
            flush_cnt  <= '0;
        end else begin
            if (state == INIT) begin
                hold_full  <= 1'b0;
                byte_idx   <= '0;
                last_taken <= 1'b0;
            end else if (state == FEED) begin
                if (accept) begin
                    hold_data  <= s_data;
                    hold_full  <= 1'b1;
                    byte_idx   <= '0;
                    hold_cnt   <= s_last ? nbytes_dec : 3'd4;
                    last_taken <= s_last;
                end else if (final_emit) begin
                    hold_full <= 1'b0;
                end else if (emit) begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
            if (emit) sym_q <= cur_byte;
            // Down-counter preloaded during FEED so FLUSH lasts exactly FLUSH_CYCLES cycles.
            if (state == FEED)
                flush_cnt <= 4'(FLUSH_CYCLES - 1);
            else if (state == FLUSH && flush_cnt != 4'd0)
                flush_cnt <= flush_cnt - 4'd1;
        end
    end

`ifdef VASIM_FEEDER_OFFSET_EN
    logic [31:0] offset_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            offset_q <= '0;
        else if ((state == IDLE && s_valid) || state == INIT)
            offset_q <= '0;
        else if (emit)
            offset_q <= offset_q + 32'd1;
    end

    assign sym_offset = offset_q;
`else
    assign sym_offset = '0;
`endif

endmodule

// File: tb/tb_vasim_symbol_feeder.sv
// Self-checking bench for vasim_symbol_feeder: table of stream vectors plus an expected-symbol scoreboard queue.
module tb_vasim_symbol_feeder;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [2:0]  s_nbytes = 3'd4;
    logic        halt = 1'b0;
    logic [7:0]  symbols;
    logic        run;
    logic        ste_reset;
    logic [31:0] sym_offset;
    logic        busy;
    logic        done;

    vasim_symbol_feeder #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_nbytes(s_nbytes), .halt(halt), .symbols(symbols), .run(run),
        .ste_reset(ste_reset), .sym_offset(sym_offset), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               nwords;
        logic [3:0][31:0] w;
        logic [2:0]       nb;
        int               halt_at;
        int               halt_len;
        int               gap;
    } vec_t;

    typedef struct {
        logic [7:0]  sym;
        logic [31:0] off;
        logic        rdy;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_off;
    logic [7:0]  last_sym = 8'h00;
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [2:0] nb,
                                input int ha, input int hl, input int gap);
        vec_t v;
        v.nwords = n;
        v.w = {32'h0, c, b, a};
        v.nb = nb;
        v.halt_at = ha;
        v.halt_len = hl;
        v.gap = gap;
        return v;
    endfunction

    task automatic push_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
        int cnt;
        exp_t e;
        cnt = 4;
        if (last && nb >= 3'd1 && nb <= 3'd4) cnt = int'(nb);
        for (int j = 0; j < cnt; j++) begin
            e.sym = 8'(w >> (8 * j));
`ifdef VASIM_FEEDER_OFFSET_EN
            e.off = exp_off;
`else
            e.off = 32'h0;
`endif
            e.rdy = (j == cnt - 1) && !last;
            sb.push_back(e);
            exp_off++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   widx = 0;
        int   k = 0;
        int   runs = 0;
        int   since_last = -1;
        int   halt_left = v.halt_len;
        int   gap_left = 0;
        bit   got_done = 0;
        exp_t e;
        exp_off = 0;
        while (!got_done && k < 300) begin
            @(negedge clk);
            halt = (runs == v.halt_at && halt_left > 0);
            if (halt) halt_left--;
            if (gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else if (widx < v.nwords) begin
                s_valid  = 1'b1;
                s_data   = v.w[widx];
                s_last   = (widx == v.nwords - 1);
                s_nbytes = v.nb;
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (k == 0) begin
                chk($sformatf("v%0d idle_busy", id), busy, 0);
                chk($sformatf("v%0d idle_ste_reset", id), ste_reset, 1);
                chk($sformatf("v%0d idle_s_ready", id), s_ready, 0);
            end else if (k == 1) begin
                chk($sformatf("v%0d init_busy", id), busy, 1);
                chk($sformatf("v%0d init_ste_reset", id), ste_reset, 1);
                chk($sformatf("v%0d init_run", id), run, 0);
                chk($sformatf("v%0d init_s_ready", id), s_ready, 0);
                chk($sformatf("v%0d init_offset", id), sym_offset, 0);
            end else begin
                chk($sformatf("v%0d feed_ste_reset k=%0d", id, k), ste_reset, 0);
            end
            if (halt) begin
                chk($sformatf("v%0d halt_run", id), run, 0);
                chk($sformatf("v%0d halt_s_ready", id), s_ready, 0);
                chk($sformatf("v%0d halt_symbols", id), symbols, last_sym);
                if (sb.size() > 0) chk($sformatf("v%0d halt_offset", id), sym_offset, sb[0].off);
            end
            if (run) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected_run", id), run, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d symbol#%0d", id, runs), symbols, e.sym);
                    chk($sformatf("v%0d offset#%0d", id, runs), sym_offset, e.off);
                    chk($sformatf("v%0d s_ready#%0d", id, runs), s_ready, e.rdy);
                end
                last_sym = symbols;
                runs++;
                since_last = 0;
            end else begin
                if (since_last >= 0) since_last++;
                if (k >= 2 && !halt && !done && widx == v.nwords && sb.size() == 0)
                    chk($sformatf("v%0d flush_s_ready", id), s_ready, 0);
                if (done) begin
                    got_done = 1;
                    chk($sformatf("v%0d done_gap", id), since_last, FC + 1);
                    chk($sformatf("v%0d done_pending", id), sb.size(), 0);
                end
            end
            if (s_valid && s_ready) begin
                push_word(v.w[widx], s_last, s_nbytes);
                widx++;
                if (widx < v.nwords) gap_left = v.gap;
            end
            k++;
        end
        s_valid = 1'b0;
        halt = 1'b0;
        if (!got_done) chk($sformatf("v%0d done_timeout", id), 0, 1);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d done_one_cycle", id), done, 0);
        chk($sformatf("v%0d back_to_idle", id), busy, 0);
        sb.delete();
    endtask

    initial begin
        int runs;
        vecs[0] = mk(1, 32'h2D2D7C2B, 32'h0, 32'h0, 3'd4, -1, 0, 0);
        vecs[1] = mk(2, 32'h04030201, 32'h08070605, 32'h0, 3'd4, -1, 0, 0);
        vecs[2] = mk(1, 32'hAABB2D7C, 32'h0, 32'h0, 3'd2, -1, 0, 0);
        vecs[3] = mk(1, 32'hDDCCBBAA, 32'h0, 32'h0, 3'd4, 1, 3, 0);
        vecs[4] = mk(2, 32'h14131211, 32'h00001615, 32'h0, 3'd2, -1, 0, 0);
        vecs[5] = mk(1, 32'h99887766, 32'h0, 32'h0, 3'd0, -1, 0, 0);
        vecs[6] = mk(3, 32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 3'd7, -1, 0, 2);
        vecs[7] = mk(1, 32'h000000F1, 32'h0, 32'h0, 3'd1, -1, 0, 0);
        vecs[8] = mk(1, 32'h88776655, 32'h0, 32'h0, 3'd4, -1, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_symbols", symbols, 0);
        chk("rst_run", run, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ste_reset", ste_reset, 1);
        chk("rst_offset", sym_offset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of FEED after two of four bytes.
        runs = 0;
        for (int c = 0; c < 40 && runs < 2; c++) begin
            @(negedge clk);
            s_valid  = 1'b1;
            s_data   = 32'h44332211;
            s_last   = 1'b1;
            s_nbytes = 3'd4;
            #1;
            if (run) begin
                chk($sformatf("pre_reset_symbol#%0d", runs), symbols, (runs == 0) ? 32'h11 : 32'h22);
                runs++;
            end
        end
        chk("pre_reset_runs", runs, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_symbols", symbols, 0);
        chk("mid_rst_run", run, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_ste_reset", ste_reset, 1);
        chk("mid_rst_offset", sym_offset, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        s_valid = 1'b0;
        last_sym = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[8], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
